// File: rtl/lsu_dmem_bridge.sv
// Load/store bridge from the core data port to a valid/grant/rvalid DMEM bus.
// Handles one access at a time: lane steering, load extension, fault and timeout reporting.
module lsu_dmem_bridge #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic              busy_q, rsp_valid_q, fault_q, mem_req_q, mem_we_q;
  logic [31:0]       rsp_rdata_q, mem_wdata_q;
  logic [1:0]        fault_code_q;
  logic [3:0]        mem_be_q;
  logic [ADDR_W-3:0] mem_addr_q;

  logic              illegal_s, misal_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;

  // Shift the addressed lane down and extend it according to the load type.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
    logic [31:0] lane;
    lane = d >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{lane[7]}}, lane[7:0]};
      3'b001:  return {{16{lane[15]}}, lane[15:0]};
      3'b100:  return {24'h000000, lane[7:0]};
      3'b101:  return {16'h0000, lane[15:0]};
      default: return d;
    endcase
  endfunction

  // Size 2'b11 is never legal; bit 2 is only legal for LBU/LHU.
  assign illegal_s = (req_funct3[1:0] == 2'b11) | (req_funct3[2] & (req_we | req_funct3[1]));

  // Byte-enable mask, replicated store data and alignment check for the incoming request.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = req_wdata;
    misal_s = 1'b0;
    case (req_funct3[1:0])
      2'b00: begin
        be_s    = 4'b0001 << req_addr[1:0];
        wdata_s = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_s    = 4'b0011 << {req_addr[1], 1'b0};
        wdata_s = {2{req_wdata[15:0]}};
        misal_s = req_addr[0];
      end
      2'b10: begin
        be_s    = 4'b1111;
        misal_s = |req_addr[1:0];
      end
      default: begin
        be_s    = 4'b0000;
        misal_s = 1'b0;
      end
    endcase
  end

  // Access FSM; every output is registered alongside the state transition.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0000_0000;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0000_0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            busy_q   <= 1'b1;
            if (illegal_s || misal_s) begin
              state_q      <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_rdata_q  <= 32'h0000_0000;
              fault_q      <= 1'b1;
              fault_code_q <= illegal_s ? 2'b10 : 2'b01;
            end else begin
              state_q     <= S_REQ;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_be_q    <= be_s;
              mem_addr_q  <= req_addr[ADDR_W-1:2];
              mem_wdata_q <= wdata_s;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt || cnt_q == CNT_W'(TIMEOUT - 1)) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
          end
          if (mem_gnt && mem_we_q) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= 32'h0000_0000;
          end else if (mem_gnt) begin
            state_q <= S_WAIT;
            cnt_q   <= cnt_q + CNT_W'(1);
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_rdata_q  <= 32'h0000_0000;
            fault_q      <= 1'b1;
            fault_code_q <= 2'b11;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_extract(funct3_q, off_q, mem_rdata);
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_rdata_q  <= 32'h0000_0000;
            fault_q      <= 1'b1;
            fault_code_q <= 2'b11;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          rsp_valid_q  <= 1'b0;
          rsp_rdata_q  <= 32'h0000_0000;
          fault_q      <= 1'b0;
          fault_code_q <= 2'b00;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_dmem_bridge.sv
// Directed bench for lsu_dmem_bridge: loads, stores, faults, timeout and mid-access reset.
module tb_lsu_dmem_bridge;

  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 64;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              busy, rsp_valid, fault, mem_req, mem_we;
  logic [31:0]       rsp_rdata, mem_wdata;
  logic [1:0]        fault_code;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [31:0]       mem_rdata = 32'h0;

  int tests_run = 0;
  int tests_failed = 0;

  lsu_dmem_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .fault(fault), .fault_code(fault_code),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present a request in cycle 0; returns positioned in cycle 1.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    step();
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = 32'h0;
  endtask

  // Load with gnt in cycle 1 and rvalid in cycle 2; response expected in cycle 3.
  task automatic quick_load(input string tag, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                            input logic [31:0] rd, input logic [3:0] exp_be,
                            input logic [31:0] exp_data);
    issue(1'b0, f3, a, 32'h0);
    check({tag, " be"}, {28'h0, mem_be}, {28'h0, exp_be});
    check({tag, " req"}, {31'h0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    check({tag, " rsp_valid"}, {31'h0, rsp_valid}, 32'd1);
    check({tag, " rdata"}, rsp_rdata, exp_data);
    check({tag, " fault"}, {31'h0, fault}, 32'd0);
    step();
  endtask

  // Request rejected at acceptance: response in cycle 1 without touching the bus.
  task automatic fault_case(input string tag, input logic we, input logic [2:0] f3,
                            input logic [ADDR_W-1:0] a, input logic [1:0] code);
    issue(we, f3, a, 32'hFFFF_FFFF);
    check({tag, " no mem_req"}, {31'h0, mem_req}, 32'd0);
    check({tag, " rsp_valid"}, {31'h0, rsp_valid}, 32'd1);
    check({tag, " fault"}, {31'h0, fault}, 32'd1);
    check({tag, " code"}, {30'h0, fault_code}, {30'h0, code});
    check({tag, " rdata"}, rsp_rdata, 32'h0);
    step();
    check({tag, " idle"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;

    repeat (2) @(posedge CLK);
    #1;
    check("reset busy", {31'h0, busy}, 32'd0);
    check("reset rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("reset mem_req", {31'h0, mem_req}, 32'd0);
    check("reset mem_be", {28'h0, mem_be}, 32'd0);
    #3 RSTn = 1'b1;
    step();

    // LW 0x008: gnt cycle 1, rvalid cycle 3, response cycle 4.
    issue(1'b0, 3'b010, 12'h008, 32'h0);
    check("lw mem_req", {31'h0, mem_req}, 32'd1);
    check("lw mem_addr", {22'h0, mem_addr}, 32'd2);
    check("lw mem_be", {28'h0, mem_be}, 32'hF);
    check("lw mem_we", {31'h0, mem_we}, 32'd0);
    check("lw busy", {31'h0, busy}, 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("lw wait mem_req", {31'h0, mem_req}, 32'd0);
    check("lw wait rsp", {31'h0, rsp_valid}, 32'd0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    check("lw rsp_valid", {31'h0, rsp_valid}, 32'd1);
    check("lw rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("lw fault", {31'h0, fault}, 32'd0);
    step();
    check("lw rsp pulse", {31'h0, rsp_valid}, 32'd0);
    check("lw idle", {31'h0, busy}, 32'd0);

    quick_load("lb", 3'b000, 12'h003, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80);
    quick_load("lbu", 3'b100, 12'h003, 32'h8012_3456, 4'b1000, 32'h0000_0080);
    quick_load("lh", 3'b001, 12'h002, 32'h8012_3456, 4'b1100, 32'hFFFF_8012);
    quick_load("lhu", 3'b101, 12'h000, 32'h0000_F00F, 4'b0011, 32'h0000_F00F);
    quick_load("lb1", 3'b000, 12'h001, 32'h0000_7F00, 4'b0010, 32'h0000_007F);

    // SH 0x006 with gnt only in the third request cycle.
    issue(1'b1, 3'b001, 12'h006, 32'h1234_ABCD);
    for (int i = 0; i < 3; i++) begin
      check("sh mem_req held", {31'h0, mem_req}, 32'd1);
      check("sh mem_be", {28'h0, mem_be}, 32'hC);
      check("sh mem_wdata", mem_wdata, 32'hABCD_ABCD);
      check("sh mem_we", {31'h0, mem_we}, 32'd1);
      mem_rvalid = 1'b1;
      if (i == 2) mem_gnt = 1'b1;
      step();
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check("sh rsp_valid", {31'h0, rsp_valid}, 32'd1);
    check("sh mem_req drop", {31'h0, mem_req}, 32'd0);
    check("sh rdata", rsp_rdata, 32'h0);
    check("sh fault", {31'h0, fault}, 32'd0);
    step();

    // SB replicates the byte.
    issue(1'b1, 3'b000, 12'h001, 32'h0000_00A5);
    check("sb mem_be", {28'h0, mem_be}, 32'h2);
    check("sb mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("sb rsp_valid", {31'h0, rsp_valid}, 32'd1);
    step();

    fault_case("lw mis", 1'b0, 3'b010, 12'h002, 2'b01);
    fault_case("lh mis", 1'b0, 3'b001, 12'h001, 2'b01);
    fault_case("sw f3", 1'b1, 3'b011, 12'h000, 2'b10);
    fault_case("ld f3 prio", 1'b0, 3'b011, 12'h001, 2'b10);
    fault_case("sbu f3", 1'b1, 3'b100, 12'h000, 2'b10);

    // Load with no grant: timeout response in cycle TIMEOUT+1.
    issue(1'b0, 3'b010, 12'h010, 32'h0);
    cyc = 1;
    while (!rsp_valid && cyc < 200) begin
      step();
      cyc++;
    end
    check("to cycle", cyc, TIMEOUT + 1);
    check("to code", {30'h0, fault_code}, 32'd3);
    check("to fault", {31'h0, fault}, 32'd1);
    check("to rdata", rsp_rdata, 32'h0);
    check("to mem_req", {31'h0, mem_req}, 32'd0);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_5555;
    step();
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check("to late rsp", {31'h0, rsp_valid}, 32'd0);
    check("to late busy", {31'h0, busy}, 32'd0);
    check("to late mem_req", {31'h0, mem_req}, 32'd0);

    // Reset while waiting for read data abandons the access.
    issue(1'b0, 3'b010, 12'h00C, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("rst pre busy", {31'h0, busy}, 32'd1);
    RSTn = 1'b0;
    #1;
    check("rst busy", {31'h0, busy}, 32'd0);
    check("rst mem_req", {31'h0, mem_req}, 32'd0);
    #2 RSTn = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h9999_9999;
    step();
    mem_rvalid = 1'b0;
    check("rst no rsp", {31'h0, rsp_valid}, 32'd0);
    quick_load("post rst lw", 3'b010, 12'h00C, 32'h1122_3344, 4'b1111, 32'h1122_3344);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
